// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
// seven_seg_scan_if : digit-code input and scan output bundle for seven_seg_scan
// Revision: 1.0
// ============================================================================
interface seven_seg_scan_if;
  logic [15:0] digit_code;
  logic [3:0]  dp_mask;
  logic        lz_en;
  logic        load;
  logic [3:0]  Anode_Activate;
  logic [7:0]  seg;
  logic        frame_sync;
  logic        pending;

  modport master (
    output digit_code, dp_mask, lz_en, load,
    input  Anode_Activate, seg, frame_sync, pending
  );

  modport slave (
    input  digit_code, dp_mask, lz_en, load,
    output Anode_Activate, seg, frame_sync, pending
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// seven_seg_scan : double-buffered 4-digit seven-segment scan driver
// Revision: 1.0
// ============================================================================
module seven_seg_scan #(
  parameter int unsigned CLK_DIV      = 5000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  wire logic       clk_in,
  input  wire logic       reset,
  seven_seg_scan_if.slave bus
);

  localparam int              c_PW   = $clog2(CLK_DIV);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(CLK_DIV - 1);

  logic [c_PW-1:0] r_presc;
  logic [1:0]      r_slot;
  logic [15:0]     r_sh_code, r_act_code;
  logic [3:0]      r_sh_dp, r_act_dp;
  logic            r_sh_lz, r_act_lz;
  logic            r_pending;
  logic [3:0]      r_anode;
  logic [7:0]      r_seg;
  logic            r_fsync;

  logic            w_wrap, w_boundary, w_blank;
  logic [3:0]      w_c1, w_c2, w_c3, w_c4;
  logic [2:0]      w_sup;
  logic            w_left2, w_left3;
  logic [3:0]      w_code, w_anode;
  logic            w_dp, w_sup_cur;
  logic [6:0]      w_glyph;
  logic [7:0]      w_seg_lit;

  assign w_wrap     = (r_presc == c_LAST);
  assign w_boundary = w_wrap && (r_slot == 2'd3);

  generate
    if (BLANK_CYCLES > 0) begin : g_gap
      assign w_blank = (r_presc < c_PW'(BLANK_CYCLES));
    end else begin : g_no_gap
      assign w_blank = 1'b0;
    end
  endgenerate

  assign w_c1 = r_act_code[15:12];
  assign w_c2 = r_act_code[11:8];
  assign w_c3 = r_act_code[7:4];
  assign w_c4 = r_act_code[3:0];

  // A zero is suppressed only while everything to its left is already dark.
  assign w_sup[0] = r_act_lz && (w_c1 == 4'd0);
  assign w_left2  = w_sup[0] || (w_c1 == 4'd11);
  assign w_sup[1] = r_act_lz && (w_c2 == 4'd0) && w_left2;
  assign w_left3  = w_left2 && (w_sup[1] || (w_c2 == 4'd11));
  assign w_sup[2] = r_act_lz && (w_c3 == 4'd0) && w_left3;

  always_comb begin
    w_code    = w_c4;
    w_anode   = 4'b1110;
    w_dp      = r_act_dp[0];
    w_sup_cur = 1'b0;
    case (r_slot)
      2'd0: begin w_code = w_c1; w_anode = 4'b0111; w_dp = r_act_dp[3]; w_sup_cur = w_sup[0]; end
      2'd1: begin w_code = w_c2; w_anode = 4'b1011; w_dp = r_act_dp[2]; w_sup_cur = w_sup[1]; end
      2'd2: begin w_code = w_c3; w_anode = 4'b1101; w_dp = r_act_dp[1]; w_sup_cur = w_sup[2]; end
      default: begin w_code = w_c4; w_anode = 4'b1110; w_dp = r_act_dp[0]; w_sup_cur = 1'b0; end
    endcase
  end

  always_comb begin
    w_glyph = 7'h7F;
    case (w_code)
      4'd0:  w_glyph = 7'h40;
      4'd1:  w_glyph = 7'h79;
      4'd2:  w_glyph = 7'h24;
      4'd3:  w_glyph = 7'h30;
      4'd4:  w_glyph = 7'h19;
      4'd5:  w_glyph = 7'h12;
      4'd6:  w_glyph = 7'h02;
      4'd7:  w_glyph = 7'h78;
      4'd8:  w_glyph = 7'h00;
      4'd9:  w_glyph = 7'h10;
      4'd10: w_glyph = 7'h3F;
      4'd12: w_glyph = 7'h06;
      4'd13: w_glyph = 7'h2F;
      4'd14: w_glyph = 7'h2F;
      default: w_glyph = 7'h7F;
    endcase
  end

  assign w_seg_lit = w_sup_cur ? 8'hFF : {~w_dp, w_glyph};

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_presc    <= '0;
      r_slot     <= 2'd0;
      r_sh_code  <= 16'hBBBB;
      r_act_code <= 16'hBBBB;
      r_sh_dp    <= 4'h0;
      r_act_dp   <= 4'h0;
      r_sh_lz    <= 1'b0;
      r_act_lz   <= 1'b0;
      r_pending  <= 1'b0;
      r_anode    <= 4'hF;
      r_seg      <= 8'hFF;
      r_fsync    <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) r_slot <= r_slot + 2'd1;

      if (w_boundary && r_pending) begin
        r_act_code <= r_sh_code;
        r_act_dp   <= r_sh_dp;
        r_act_lz   <= r_sh_lz;
      end

      // A load on the boundary edge refills the shadow, so pending stays set.
      if (bus.load) begin
        r_sh_code <= bus.digit_code;
        r_sh_dp   <= bus.dp_mask;
        r_sh_lz   <= bus.lz_en;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end

      r_anode <= w_blank ? 4'hF  : w_anode;
      r_seg   <= w_blank ? 8'hFF : w_seg_lit;
      r_fsync <= (r_slot == 2'd0) && (r_presc == '0);
    end
  end

  assign bus.Anode_Activate = r_anode;
  assign bus.seg            = r_seg;
  assign bus.frame_sync     = r_fsync;
  assign bus.pending        = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// Self-checking bench for seven_seg_scan: expected slot patterns are queued
// as loads are issued and popped as each displayed frame is observed.
module tb_seven_seg_scan;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } slot_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seven_seg_scan_if u_if ();

  seven_seg_scan #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK)
  ) u_dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (u_if.slave)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  slot_t exp_q[$];
  logic  prev_bnd = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back({4'b0111, s0});
    exp_q.push_back({4'b1011, s1});
    exp_q.push_back({4'b1101, s2});
    exp_q.push_back({4'b1110, s3});
  endtask

  task automatic drive_load(input logic [15:0] code, input logic [3:0] dp, input logic lz);
    u_if.digit_code = code;
    u_if.dp_mask    = dp;
    u_if.lz_en      = lz;
    u_if.load       = 1'b1;
    @(negedge clk);
    u_if.load       = 1'b0;
  endtask

  // Observes one full frame starting at its frame_sync cycle; optionally
  // issues a mid-frame load and/or a load landing on the closing boundary edge.
  task automatic check_frame(input string name,
                             input logic mid_en, input logic [15:0] mid_code,
                             input logic bnd_en, input logic [15:0] bnd_code);
    int    waited;
    int    fs_cnt;
    slot_t exp_s;
    slot_t lit;
    logic  gap_ok;
    logic  stable_ok;
    waited = 0;
    fs_cnt = 0;
    while (u_if.frame_sync !== 1'b1 && waited < 3 * 4 * CLK_DIV) begin
      @(negedge clk);
      waited++;
    end
    check_eq({name, "/sync_seen"}, 16'(u_if.frame_sync), 16'h1);
    if (u_if.frame_sync !== 1'b1) return;
    for (int s = 0; s < 4; s++) begin
      exp_s     = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
      lit       = 12'h000;
      gap_ok    = 1'b1;
      stable_ok = 1'b1;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (u_if.frame_sync === 1'b1) fs_cnt++;
        if (c < BLANK) begin
          if (u_if.Anode_Activate !== 4'hF || u_if.seg !== 8'hFF) gap_ok = 1'b0;
        end else if (c == BLANK) begin
          lit = {u_if.Anode_Activate, u_if.seg};
        end else if ({u_if.Anode_Activate, u_if.seg} !== lit) begin
          stable_ok = 1'b0;
        end
        if (s == 2 && c == 0)
          check_eq({name, "/pending_mid"}, 16'(u_if.pending), 16'(mid_en || prev_bnd));
        if (s == 3 && c == CLK_DIV - 1)
          check_eq({name, "/pending_after_boundary"}, 16'(u_if.pending), 16'(bnd_en));
        u_if.load = 1'b0;
        if (mid_en && s == 1 && c == 3) begin
          u_if.digit_code = mid_code; u_if.dp_mask = 4'h0; u_if.lz_en = 1'b0; u_if.load = 1'b1;
        end
        if (bnd_en && s == 3 && c == CLK_DIV - 2) begin
          u_if.digit_code = bnd_code; u_if.dp_mask = 4'h0; u_if.lz_en = 1'b0; u_if.load = 1'b1;
        end
        @(negedge clk);
      end
      check_eq($sformatf("%s/slot%0d_gap", name, s), 16'(gap_ok), 16'h1);
      check_eq($sformatf("%s/slot%0d_anode", name, s), 16'(lit.an), 16'(exp_s.an));
      check_eq($sformatf("%s/slot%0d_seg", name, s), 16'(lit.seg), 16'(exp_s.seg));
      check_eq($sformatf("%s/slot%0d_stable", name, s), 16'(stable_ok), 16'h1);
    end
    check_eq({name, "/frame_sync_count"}, 16'(fs_cnt), 16'h1);
    prev_bnd = bnd_en;
  endtask

  initial begin
    u_if.digit_code = 16'h0;
    u_if.dp_mask    = 4'h0;
    u_if.lz_en      = 1'b0;
    u_if.load       = 1'b0;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst/anode", 16'(u_if.Anode_Activate), 16'hF);
    check_eq("rst/seg", 16'(u_if.seg), 16'hFF);
    check_eq("rst/frame_sync", 16'(u_if.frame_sync), 16'h0);
    check_eq("rst/pending", 16'(u_if.pending), 16'h0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("start/gap0_anode", 16'(u_if.Anode_Activate), 16'hF);
    check_eq("start/gap0_seg", 16'(u_if.seg), 16'hFF);
    check_eq("start/frame_sync", 16'(u_if.frame_sync), 16'h1);
    @(negedge clk);
    check_eq("start/gap1_anode", 16'(u_if.Anode_Activate), 16'hF);
    check_eq("start/gap1_seg", 16'(u_if.seg), 16'hFF);
    @(negedge clk);
    check_eq("start/lit_anode", 16'(u_if.Anode_Activate), 16'h7);
    check_eq("start/lit_seg", 16'(u_if.seg), 16'hFF);
    check_eq("start/pending", 16'(u_if.pending), 16'h0);

    drive_load(16'h1234, 4'h0, 1'b0);
    check_eq("load1234/pending", 16'(u_if.pending), 16'h1);
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check_frame("f1234", 1'b0, 16'h0, 1'b0, 16'h0);

    drive_load(16'h0050, 4'b1000, 1'b1);
    push_frame(8'hFF, 8'hFF, 8'h92, 8'hC0);
    check_frame("f0050lz", 1'b0, 16'h0, 1'b0, 16'h0);

    drive_load(16'h0000, 4'h0, 1'b1);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hC0);
    check_frame("f0000lz", 1'b0, 16'h0, 1'b0, 16'h0);

    drive_load(16'hBCDE, 4'h0, 1'b1);
    push_frame(8'hFF, 8'h86, 8'hAF, 8'hAF);
    check_frame("fBCDE", 1'b0, 16'h0, 1'b0, 16'h0);

    drive_load(16'hA007, 4'h0, 1'b0);
    push_frame(8'hBF, 8'hC0, 8'hC0, 8'hF8);
    check_frame("fA007", 1'b0, 16'h0, 1'b0, 16'h0);

    drive_load(16'h1111, 4'h0, 1'b0);
    drive_load(16'h2222, 4'h0, 1'b0);
    push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    push_frame(8'hC0, 8'hC0, 8'h92, 8'hC0);
    check_frame("flastwins", 1'b1, 16'h1234, 1'b1, 16'h0050);
    check_frame("fmid", 1'b0, 16'h0, 1'b0, 16'h0);
    check_frame("fbnd", 1'b0, 16'h0, 1'b0, 16'h0);

    drive_load(16'h1234, 4'b0100, 1'b0);
    push_frame(8'hF9, 8'h24, 8'hB0, 8'h99);
    check_frame("fdp", 1'b0, 16'h0, 1'b0, 16'h0);

    repeat (2 * CLK_DIV + 3) @(negedge clk);
    drive_load(16'h8888, 4'hF, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst/anode", 16'(u_if.Anode_Activate), 16'hF);
    check_eq("midrst/seg", 16'(u_if.seg), 16'hFF);
    check_eq("midrst/frame_sync", 16'(u_if.frame_sync), 16'h0);
    check_eq("midrst/pending", 16'(u_if.pending), 16'h0);
    reset = 1'b0;
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check_frame("fpostrst", 1'b0, 16'h0, 1'b0, 16'h0);
    check_frame("fpostrst2", 1'b0, 16'h0, 1'b0, 16'h0);

    check_eq("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
